vram_port_arbiter: RTL
======================

Name: vram_port_arbiter

Overview:
- Shares the single-port screen memory between the Hack CPU and the video scanout fetcher.
- Each cycle it selects one requester and drives the shared address/write-data path. It does this by steering the 16-bit word mux select plus the address and write-enable lines.
- It routes the synchronous-read return data back to the requester that issued the read.
- Video has fixed priority. A starvation counter guarantees the CPU forward progress.

Parameters:
- ADDR_W, 13, word address width (8K-word screen map)
- DATA_W, 16, data word width
- MAX_WAIT, 4, consecutive denied CPU cycles after which the CPU is forced to win (1..15)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- cpu_req  input  1  CPU access request; held high until cpu_gnt
- cpu_we  input  1  1 = write, 0 = read; valid with cpu_req
- cpu_addr  input  ADDR_W  CPU word address
- cpu_wdata  input  DATA_W  CPU write data
- cpu_gnt  output  1  access issued this cycle
- cpu_rvalid  output  1  cpu_rdata valid
- cpu_rdata  output  DATA_W  read return data
- vid_req  input  1  video read request; held until vid_gnt
- vid_addr  input  ADDR_W  video word address
- vid_gnt  output  1  access issued this cycle
- vid_rvalid  output  1  vid_rdata valid
- vid_rdata  output  DATA_W  read return data
- mem_sel  output  1  shared mux select; 1 = CPU path, 0 = video path
- mem_addr  output  ADDR_W  memory address
- mem_we  output  1  memory write enable
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid one cycle after address

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All registers update on rising clk.
- Reset values: wait_cnt=0; cpu_rvalid=0 and vid_rvalid=0 (registered). Combinational outputs follow the idle rule below while the reqs are low.
- Arbitration is combinational on the current cycle's inputs:
  - force = cpu_req && (wait_cnt == MAX_WAIT).
  - cpu_gnt = cpu_req && (!vid_req || force).
  - vid_gnt = vid_req && !cpu_gnt.
  - cpu_gnt and vid_gnt are never both 1.
- Memory drive:
  - When cpu_gnt: mem_sel=1, mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
  - Otherwise: mem_sel=0, mem_addr=vid_addr, mem_we=0, mem_wdata=cpu_wdata (don't care).
  - mem_we is 1 only when cpu_gnt && cpu_we.
  - Idle (no grant): mem_sel=0, mem_we=0.
- Starvation counter wait_cnt (4 bits):
  - cpu_gnt → 0.
  - else cpu_req → wait_cnt+1, saturating at MAX_WAIT.
  - else → 0.
- Read return (1-cycle latency, registered):
  - cpu_rvalid <= cpu_gnt && !cpu_we.
  - vid_rvalid <= vid_gnt.
  - cpu_rdata = vid_rdata = mem_rdata (combinational pass-through). Data is meaningful only when the matching rvalid is 1.
  - CPU writes produce no rvalid.
- Back-to-back: a new grant may be issued in the same cycle a previous read's rvalid is high. Throughput is one access per cycle.
- Simultaneous requests:
  - Video wins unless force is true.
  - With both continuously requesting, the CPU is granted exactly once every MAX_WAIT+1 cycles.
- Requester drops req without a grant: no access is issued and wait_cnt clears.
- Reset mid-operation:
  - A read granted in the cycle reset is asserted yields rvalid=0 on the next cycle.
  - Combinational grants still follow the inputs during reset, but wait_cnt is held at 0.

Test Plan:
1. Reset, then CPU-only read addr 0x0100 with mem model returning 0xBEEF → cpu_gnt same cycle, mem_sel=1, mem_we=0; next cycle cpu_rvalid=1, cpu_rdata=0xBEEF; vid_rvalid stays 0.
2. CPU write addr 0x1FFF data 0xA5A5 → mem_we=1 for exactly one cycle, mem_sel=1; no cpu_rvalid; readback via video at 0x1FFF returns 0xA5A5.
3. Both requesting continuously for 20 cycles, MAX_WAIT=4 → vid_gnt 4 cycles, cpu_gnt 1 cycle, repeating; CPU grant at cycles 4, 9, 14, 19; never both grants high.
4. Video streaming reads 0x0000..0x000F back-to-back → vid_gnt every cycle; vid_rvalid on 16 consecutive cycles, each one cycle late; data order matches addresses.
5. Reset asserted in the same cycle as a granted video read → vid_rvalid=0 on the next cycle; wait_cnt=0 afterwards, so the CPU must again wait 4 cycles under contention.
6. CPU requests 2 cycles under contention, then drops req, then re-requests → wait_cnt clears; forced CPU grant occurs only after 4 further denied cycles.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter
//   Shares the single-port screen memory between the Hack CPU and the video
//   scanout fetcher. Video has fixed priority. A starvation counter forces a
//   CPU win after MAX_WAIT consecutive denied cycles, so the CPU keeps making
//   progress. Read data from the synchronous memory comes back one cycle
//   later. It is flagged to whichever requester issued the read.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request (req held until cpu_gnt)
//   cpu_gnt                        CPU access issued this cycle
//   cpu_rvalid/rdata               CPU read return (rdata valid with rvalid)
//   vid_req/addr                   video read request (held until vid_gnt)
//   vid_gnt                        video access issued this cycle
//   vid_rvalid/rdata               video read return
//   mem_sel                        shared mux select, 1 = CPU, 0 = video
//   mem_addr/we/wdata              memory drive
//   mem_rdata                      memory read data, one cycle after address
module vram_port_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MAX_W4 = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       force_cpu;

  // The grant is decided combinationally. The memory sees the address in
  // the same cycle the requester sees its grant.
  always_comb begin
    force_cpu = cpu_req && (wait_cnt == MAX_W4);
    cpu_gnt   = cpu_req && (!vid_req || force_cpu);
    vid_gnt   = vid_req && !cpu_gnt;
    mem_sel   = cpu_gnt;
    mem_addr  = cpu_gnt ? cpu_addr : vid_addr;
    mem_we    = cpu_gnt && cpu_we;
    mem_wdata = cpu_wdata;
  end

  // The memory read port is shared. The rvalid flags tell each requester
  // which cycle's data belongs to it.
  assign cpu_rdata = mem_rdata;
  assign vid_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= '0;
      cpu_rvalid <= 1'b0;
      vid_rvalid <= 1'b0;
    end else begin
      // Counts consecutive denied CPU cycles. It clears on a grant, or when
      // the CPU withdraws its request.
      if (cpu_gnt)
        wait_cnt <= '0;
      else if (cpu_req)
        wait_cnt <= (wait_cnt == MAX_W4) ? wait_cnt : wait_cnt + 4'd1;
      else
        wait_cnt <= '0;
      cpu_rvalid <= cpu_gnt && !cpu_we;
      vid_rvalid <= vid_gnt;
    end
  end

endmodule
